srt4_control_unit: RTL and testbench
====================================

Name: srt4_control_unit

Overview:
- Sequencer for the radix-4 SRT divider datapath (P 9-bit partial remainder, A/A' 8-bit quotient registers, B 8-bit divisor).
- Reads datapath status and generates the edge-triggered control strobes c0..c14 that the datapath registers act on.
- Covers the full divide: load, divisor normalisation, radix-4 iterations, sign correction, quotient conversion and denormalisation.

Parameters:
- ITER, 4, number of radix-4 iterations (quotient width / 2).
- KMAX, 7, maximum normalisation shifts; width of the shift counter is 3.
- T1, 2, digit-selection threshold for |q| >= 1 (signed compare on the P estimate).
- T2, 6, digit-selection threshold for |q| = 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_b  in  1  asynchronous active-low reset.
- start  in  1  begin a divide; sampled only in IDLE.
- b_msb  in  1  B[7] from the datapath.
- b_zero  in  1  B == 0 from the datapath.
- p_q  in  9  current P register value.
- c  out  15  control strobes c[14:0].
- busy  out  1  high from the cycle after start is accepted until DONE.
- done  out  1  one-cycle pulse at completion.
- div_by_zero  out  1  sticky error flag, cleared on the next accepted start.
- norm_cnt  out  3  number of normalisation shifts k.

Behaviour:
- Reset (async, rst_b low): state IDLE; c=0, busy=0, done=0, div_by_zero=0, norm_cnt=0.
- Every output is driven straight from a flop, so outputs are glitch-free. The datapath is clocked by c edges.
- Strobes: c0 clears P/A' and loads A; c1 loads B; c2 normalisation shift left by 1; c3 shift left by 2; c8 loads P from the adder; c11 P <= P+B; c12 A' <= A'+1; c13 A <= A-A'; c14 shifts P right by 1.
- Qualifiers:
  - c4, c5, c6, c7 qualify c3: c4 gives A digit 01, c7 gives A digit 10, c5 gives A' digit 01, c6 gives A' digit 10.
  - c9 and c10 qualify c8: c9 selects subtract, c10 selects the 2B operand.
  - Qualifiers are high for the setup cycle and for the following strobe cycle. They are never raised in the same cycle as their strobe edge.
- FSM sequence:
  - IDLE: on start, go to LOAD.
  - LOAD asserts c0. LOADB asserts c1.
  - NORM: if b_zero, go to ERR. Else if b_msb=1 or k=KMAX, go to QSEL. Else go to NSH.
  - NSH asserts c2 and increments k, then returns to NORM.
- Digit selection in QSEL: pe = signed p_q[6:2], the value that becomes P[8:4] after the shift.
  - pe >= T2 gives q=+2; pe >= T1 gives +1; pe >= -T1 gives 0; pe >= -T2 gives -1; else -2.
  - QSEL drives the qualifiers for q.
- Iteration states:
  - SH asserts c3 with the qualifiers.
  - If q=0, skip ASET/ADD.
  - ASET drives the c9/c10 qualifiers: q=+1 gives c9; +2 gives c9+c10; -1 gives none; -2 gives c10.
  - ADD asserts c8 with the same qualifiers.
  - The iteration counter increments after SH. When it reaches ITER, go to FIX.
- FIX: if p_q[8]=1, go to CORR, which asserts c11 and c12 together; else go straight to CONV.
- CONV asserts c13.
- DEN asserts c14 once per cycle, k times (zero times if k=0).
- DONE: done=1 for one cycle, then IDLE.
- ERR: div_by_zero=1, done pulse, then IDLE. No further strobes.
- start while busy is ignored.
- rst_b low mid-operation: immediate return to IDLE with all strobes low. No strobe is left high.
- At most one strobe among {c0,c1,c2,c3,c8,c11/c12,c13,c14} is high in any cycle.

Decomposition:
- Package srt4_pkg holds:
  - the state enum;
  - strobe index constants C0..C14;
  - the digit type (-2..+2);
  - the default thresholds.
- Sub-module srt4_digit_sel: combinational pe/T1/T2 to q, plus the qualifier encoding. It is reused by the datapath checker in the bench.

Test Plan:
- Normalised divisor: B=0x90, dividend A=0x64, b_msb=1. Required: c0, then c1, no c2, exactly 4 c3 pulses, c14 count 0, c13 once, done once, norm_cnt=0.
- Unnormalised divisor: B=0x05 (k=5). Required: exactly 5 c2 pulses before the first c3, 5 c14 pulses after c13, norm_cnt=5.
- Digit decode: force p_q[6:2]=+7, +3, 0, -3, -7 in QSEL. Required: (c7) with c9+c10; (c4) with c9; no qualifiers and no c8; (c5) with none; (c6) with c10.
- Negative final remainder: p_q[8]=1 at FIX. Required: c11 and c12 high in the same single cycle, followed by c13.
- Divide by zero: b_zero=1. Required: div_by_zero=1, done pulse, no c2, c3 or c8 issued; next start clears the flag.
- Async reset asserted in the middle of SH: c==0 immediately with no clk edge, busy=0; start after release runs a full clean divide.

Source files
------------

// File: rtl/srt4_pkg.sv
// rtl/srt4_pkg.sv - shared types and constants for the radix-4 SRT divider sequencer
package srt4_pkg;

  localparam int ITER_DEF = 4;
  localparam int KMAX_DEF = 7;
  localparam int T1_DEF   = 2;
  localparam int T2_DEF   = 6;

  localparam int C0  = 0;
  localparam int C1  = 1;
  localparam int C2  = 2;
  localparam int C3  = 3;
  localparam int C4  = 4;
  localparam int C5  = 5;
  localparam int C6  = 6;
  localparam int C7  = 7;
  localparam int C8  = 8;
  localparam int C9  = 9;
  localparam int C10 = 10;
  localparam int C11 = 11;
  localparam int C12 = 12;
  localparam int C13 = 13;
  localparam int C14 = 14;

  typedef logic signed [2:0] digit_t;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_LOADB, S_NORM, S_NSH, S_QSEL, S_SH, S_ASET,
    S_ADD, S_FIX, S_CORR, S_CONV, S_DEN, S_DGAP, S_DONE, S_ERR
  } state_t;

endpackage

// File: rtl/srt4_control_unit_if.sv
// rtl/srt4_control_unit_if.sv - status/strobe bundle between sequencer and datapath
interface srt4_control_unit_if;
  logic        start;
  logic        b_msb;
  logic        b_zero;
  logic [8:0]  p_q;
  logic [14:0] c;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [2:0]  norm_cnt;

  modport master (
    input  start, b_msb, b_zero, p_q,
    output c, busy, done, div_by_zero, norm_cnt
  );

  modport slave (
    output start, b_msb, b_zero, p_q,
    input  c, busy, done, div_by_zero, norm_cnt
  );
endinterface

// File: rtl/srt4_digit_sel.sv
// rtl/srt4_digit_sel.sv - quotient digit selection from the P estimate
// and the qualifier encoding that goes with each digit.
module srt4_digit_sel
  import srt4_pkg::*;
#(
  parameter int T1 = T1_DEF,
  parameter int T2 = T2_DEF
) (
  input  logic signed [4:0] pe,
  output digit_t            q,
  output logic [3:0]        sh_qual,
  output logic [1:0]        add_qual
);
  localparam logic signed [4:0] T1P = 5'(T1);
  localparam logic signed [4:0] T1N = 5'(-T1);
  localparam logic signed [4:0] T2P = 5'(T2);
  localparam logic signed [4:0] T2N = 5'(-T2);

  // sh_qual = {c7, c6, c5, c4}, add_qual = {c10, c9}
  always_comb begin
    sh_qual  = '0;
    add_qual = '0;
    if (pe >= T2P)      q = 3'sd2;
    else if (pe >= T1P) q = 3'sd1;
    else if (pe >= T1N) q = 3'sd0;
    else if (pe >= T2N) q = -3'sd1;
    else                q = -3'sd2;
    case (q)
      3'sd2:   begin sh_qual = 4'b1000; add_qual = 2'b11; end
      3'sd1:   begin sh_qual = 4'b0001; add_qual = 2'b01; end
      -3'sd1:  begin sh_qual = 4'b0010; add_qual = 2'b00; end
      -3'sd2:  begin sh_qual = 4'b0100; add_qual = 2'b10; end
      default: begin sh_qual = 4'b0000; add_qual = 2'b00; end
    endcase
  end
endmodule

// File: rtl/srt4_control_unit.sv
// rtl/srt4_control_unit.sv - sequencer issuing registered c0..c14 strobes
// for load, normalise, radix-4 iterate, correct, convert and denormalise.
module srt4_control_unit
  import srt4_pkg::*;
#(
  parameter int ITER = ITER_DEF,
  parameter int KMAX = KMAX_DEF,
  parameter int T1   = T1_DEF,
  parameter int T2   = T2_DEF
) (
  input  logic clk,
  input  logic rst_b,
  srt4_control_unit_if.master bus
);
  localparam int IW = $clog2(ITER + 1);

  state_t        state, state_nxt;
  logic [14:0]   c_r, c_nxt;
  logic          busy_r, busy_nxt, done_r, done_nxt, err_r, err_nxt;
  logic [2:0]    k_r, k_nxt, dcnt_r, dcnt_nxt;
  logic [IW-1:0] it_r, it_nxt, it_inc;
  logic [3:0]    shq_r, shq_nxt, sel_shq;
  logic [1:0]    adq_r, adq_nxt, sel_adq;
  logic          zero_r, zero_nxt;
  digit_t        q_sel;
  logic          unused_p;

  assign unused_p = ^{bus.p_q[7], bus.p_q[1:0]};
  assign it_inc   = it_r + IW'(1);

  srt4_digit_sel #(.T1(T1), .T2(T2)) u_sel (
    .pe       ($signed(bus.p_q[6:2])),
    .q        (q_sel),
    .sh_qual  (sel_shq),
    .add_qual (sel_adq)
  );

  // Outputs are computed for the state being entered so they come straight from flops.
  always_comb begin
    state_nxt = state;
    k_nxt     = k_r;
    it_nxt    = it_r;
    dcnt_nxt  = dcnt_r;
    err_nxt   = err_r;
    shq_nxt   = shq_r;
    adq_nxt   = adq_r;
    zero_nxt  = zero_r;
    c_nxt     = '0;
    busy_nxt  = 1'b1;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE:  if (bus.start) begin state_nxt = S_LOAD; err_nxt = 1'b0; k_nxt = '0; end
      S_LOAD:  state_nxt = S_LOADB;
      S_LOADB: state_nxt = S_NORM;
      S_NORM: begin
        if (bus.b_zero) state_nxt = S_ERR;
        else if (bus.b_msb || k_r == 3'(KMAX)) begin state_nxt = S_QSEL; it_nxt = '0; end
        else begin state_nxt = S_NSH; k_nxt = k_r + 3'd1; end
      end
      S_NSH:   state_nxt = S_NORM;
      S_QSEL:  state_nxt = S_SH;
      S_SH: begin
        it_nxt = it_inc;
        if (!zero_r)              state_nxt = S_ASET;
        else if (it_inc == IW'(ITER)) state_nxt = S_FIX;
        else                      state_nxt = S_QSEL;
      end
      S_ASET:  state_nxt = S_ADD;
      S_ADD:   state_nxt = (it_r == IW'(ITER)) ? S_FIX : S_QSEL;
      S_FIX:   state_nxt = bus.p_q[8] ? S_CORR : S_CONV;
      S_CORR:  state_nxt = S_CONV;
      S_CONV: begin
        if (k_r == 3'd0) state_nxt = S_DONE;
        else begin state_nxt = S_DEN; dcnt_nxt = k_r; end
      end
      // DGAP drops c14 between shifts so every shift sees its own rising edge
      S_DEN: begin
        dcnt_nxt  = dcnt_r - 3'd1;
        state_nxt = (dcnt_r == 3'd1) ? S_DONE : S_DGAP;
      end
      S_DGAP:  state_nxt = S_DEN;
      default: state_nxt = S_IDLE;
    endcase

    if (state_nxt == S_QSEL) begin
      shq_nxt  = sel_shq;
      adq_nxt  = sel_adq;
      zero_nxt = (q_sel == '0);
    end

    case (state_nxt)
      S_IDLE:  busy_nxt = 1'b0;
      S_LOAD:  c_nxt[C0] = 1'b1;
      S_LOADB: c_nxt[C1] = 1'b1;
      S_NSH:   c_nxt[C2] = 1'b1;
      S_QSEL:  c_nxt[C7:C4] = shq_nxt;
      S_SH:    begin c_nxt[C3] = 1'b1; c_nxt[C7:C4] = shq_nxt; end
      S_ASET:  c_nxt[C10:C9] = adq_nxt;
      S_ADD:   begin c_nxt[C8] = 1'b1; c_nxt[C10:C9] = adq_nxt; end
      S_CORR:  begin c_nxt[C11] = 1'b1; c_nxt[C12] = 1'b1; end
      S_CONV:  c_nxt[C13] = 1'b1;
      S_DEN:   c_nxt[C14] = 1'b1;
      S_DONE:  begin busy_nxt = 1'b0; done_nxt = 1'b1; end
      S_ERR:   begin busy_nxt = 1'b0; done_nxt = 1'b1; err_nxt = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state  <= S_IDLE;
      c_r    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
      k_r    <= '0;
      dcnt_r <= '0;
      it_r   <= '0;
      shq_r  <= '0;
      adq_r  <= '0;
      zero_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      c_r    <= c_nxt;
      busy_r <= busy_nxt;
      done_r <= done_nxt;
      err_r  <= err_nxt;
      k_r    <= k_nxt;
      dcnt_r <= dcnt_nxt;
      it_r   <= it_nxt;
      shq_r  <= shq_nxt;
      adq_r  <= adq_nxt;
      zero_r <= zero_nxt;
    end
  end

  assign bus.c           = c_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.div_by_zero = err_r;
  assign bus.norm_cnt    = k_r;
endmodule

// File: tb/tb_srt4_control_unit.sv
// tb/tb_srt4_control_unit.sv - directed self-checking bench for srt4_control_unit
module tb_srt4_control_unit;
  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  srt4_control_unit_if bus ();
  srt4_control_unit dut (.clk(clk), .rst_b(rst_b), .bus(bus));

  int tests = 0;
  int fails = 0;

  // Divisor register model: load on c1, shift left on c2.
  logic [7:0] b_init, b_reg;
  assign bus.b_msb  = b_reg[7];
  assign bus.b_zero = (b_reg == 8'h00);

  int cnt [15];
  int done_cnt, busy_cnt, multi, qual_bad, c2_late, c14_early, corr_split, corr_seq_bad, order_bad;
  logic [3:0]  last_shq;
  logic [1:0]  last_adq;
  logic [14:0] prev_c;

  always @(negedge clk) begin
    int n;
    if (bus.c[1]) b_reg <= b_init;
    else if (bus.c[2]) b_reg <= {b_reg[6:0], 1'b0};
    for (int i = 0; i < 15; i++) if (bus.c[i]) cnt[i] = cnt[i] + 1;
    if (bus.done) done_cnt = done_cnt + 1;
    if (bus.busy) busy_cnt = busy_cnt + 1;
    n = int'(bus.c[0]) + int'(bus.c[1]) + int'(bus.c[2]) + int'(bus.c[3]) + int'(bus.c[8])
      + int'(bus.c[11]) + int'(bus.c[13]) + int'(bus.c[14]);
    if (n > 1) multi = multi + 1;
    if (bus.c[3]) begin
      last_shq = bus.c[7:4];
      if (prev_c[7:4] != bus.c[7:4]) qual_bad = qual_bad + 1;
    end
    if (bus.c[8]) begin
      last_adq = bus.c[10:9];
      if (prev_c[10:9] != bus.c[10:9]) qual_bad = qual_bad + 1;
    end
    if (bus.c[2] && cnt[3] != 0) c2_late = c2_late + 1;
    if (bus.c[14] && cnt[13] == 0) c14_early = c14_early + 1;
    if (bus.c[11] != bus.c[12]) corr_split = corr_split + 1;
    if (prev_c[11] && !bus.c[13]) corr_seq_bad = corr_seq_bad + 1;
    if (bus.c[1] && cnt[0] == 0) order_bad = order_bad + 1;
    prev_c = bus.c;
  end

  task automatic clear_mon();
    for (int i = 0; i < 15; i++) cnt[i] = 0;
    done_cnt = 0; busy_cnt = 0; multi = 0; qual_bad = 0; c2_late = 0; c14_early = 0;
    corr_split = 0; corr_seq_bad = 0; order_bad = 0; last_shq = '0; last_adq = '0;
  endtask

  task automatic run_divide(input logic [7:0] b, input logic [8:0] p, input int restart_at,
                            output bit timed_out);
    b_init = b;
    bus.p_q = p;
    @(posedge clk); #1;
    clear_mon();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    timed_out = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      bus.start = (i == restart_at);
      if (done_cnt != 0) begin timed_out = 1'b0; break; end
    end
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_b = 1'b1;
    #2 rst_b = 1'b0;
    #2;
    tests++; if (bus.c !== 15'h0) begin fails++; $display("FAIL reset_c: got %h expected 0", bus.c); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    tests++; if (bus.div_by_zero !== 1'b0) begin fails++; $display("FAIL reset_dbz: got %b expected 0", bus.div_by_zero); end
    tests++; if (bus.norm_cnt !== 3'd0) begin fails++; $display("FAIL reset_k: got %0d expected 0", bus.norm_cnt); end
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b1;
  endtask

  task automatic test_normalised();
    bit to;
    run_divide(8'h90, 9'h000, -1, to);
    tests++; if (to) begin fails++; $display("FAIL norm_timeout: no done within bound"); end
    tests++; if (cnt[0] != 1) begin fails++; $display("FAIL norm_c0: got %0d expected 1", cnt[0]); end
    tests++; if (cnt[1] != 1) begin fails++; $display("FAIL norm_c1: got %0d expected 1", cnt[1]); end
    tests++; if (order_bad != 0) begin fails++; $display("FAIL norm_order: c1 before c0 %0d times", order_bad); end
    tests++; if (cnt[2] != 0) begin fails++; $display("FAIL norm_c2: got %0d expected 0", cnt[2]); end
    tests++; if (cnt[3] != 4) begin fails++; $display("FAIL norm_c3: got %0d expected 4", cnt[3]); end
    tests++; if (cnt[8] != 0) begin fails++; $display("FAIL norm_c8: got %0d expected 0", cnt[8]); end
    tests++; if (cnt[13] != 1) begin fails++; $display("FAIL norm_c13: got %0d expected 1", cnt[13]); end
    tests++; if (cnt[14] != 0) begin fails++; $display("FAIL norm_c14: got %0d expected 0", cnt[14]); end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL norm_done: got %0d expected 1", done_cnt); end
    tests++; if (busy_cnt != 13) begin fails++; $display("FAIL norm_busy_cycles: got %0d expected 13", busy_cnt); end
    tests++; if (bus.norm_cnt !== 3'd0) begin fails++; $display("FAIL norm_k: got %0d expected 0", bus.norm_cnt); end
    tests++; if (multi != 0) begin fails++; $display("FAIL norm_onehot: %0d cycles with >1 strobe", multi); end
  endtask

  task automatic test_unnormalised(input logic [7:0] b, input int k);
    bit to;
    run_divide(b, 9'h000, -1, to);
    tests++; if (to) begin fails++; $display("FAIL unnorm_timeout: b=%h", b); end
    tests++; if (cnt[2] != k) begin fails++; $display("FAIL unnorm_c2: b=%h got %0d expected %0d", b, cnt[2], k); end
    tests++; if (c2_late != 0) begin fails++; $display("FAIL unnorm_c2_after_c3: got %0d expected 0", c2_late); end
    tests++; if (cnt[14] != k) begin fails++; $display("FAIL unnorm_c14: b=%h got %0d expected %0d", b, cnt[14], k); end
    tests++; if (c14_early != 0) begin fails++; $display("FAIL unnorm_c14_before_c13: got %0d expected 0", c14_early); end
    tests++; if (bus.norm_cnt !== 3'(k)) begin fails++; $display("FAIL unnorm_k: got %0d expected %0d", bus.norm_cnt, k); end
    tests++; if (cnt[13] != 1) begin fails++; $display("FAIL unnorm_c13: got %0d expected 1", cnt[13]); end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL unnorm_done: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_digit_decode();
    logic [4:0] pe_v  [8] = '{5'd7, 5'd3, 5'd0, 5'b11101, 5'b11001, 5'd6, 5'b11010, 5'b11110};
    logic [3:0] shq_v [8] = '{4'b1000, 4'b0001, 4'b0000, 4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0000};
    logic [1:0] adq_v [8] = '{2'b11, 2'b01, 2'b00, 2'b00, 2'b10, 2'b11, 2'b00, 2'b00};
    int         c8_v  [8] = '{4, 4, 0, 4, 4, 4, 4, 0};
    bit to;
    for (int i = 0; i < 8; i++) begin
      run_divide(8'h90, {2'b00, pe_v[i], 2'b00}, -1, to);
      tests++; if (to) begin fails++; $display("FAIL digit_timeout: pe=%b", pe_v[i]); end
      tests++; if (last_shq !== shq_v[i]) begin fails++; $display("FAIL digit_shq: pe=%b got %b expected %b", pe_v[i], last_shq, shq_v[i]); end
      tests++; if (last_adq !== adq_v[i]) begin fails++; $display("FAIL digit_adq: pe=%b got %b expected %b", pe_v[i], last_adq, adq_v[i]); end
      tests++; if (cnt[8] != c8_v[i]) begin fails++; $display("FAIL digit_c8: pe=%b got %0d expected %0d", pe_v[i], cnt[8], c8_v[i]); end
      tests++; if (cnt[3] != 4) begin fails++; $display("FAIL digit_c3: pe=%b got %0d expected 4", pe_v[i], cnt[3]); end
      tests++; if (qual_bad != 0) begin fails++; $display("FAIL digit_qual_setup: pe=%b got %0d expected 0", pe_v[i], qual_bad); end
      tests++; if (multi != 0) begin fails++; $display("FAIL digit_onehot: pe=%b got %0d expected 0", pe_v[i], multi); end
    end
  endtask

  task automatic test_neg_remainder();
    bit to;
    run_divide(8'h90, 9'h100, -1, to);
    tests++; if (to) begin fails++; $display("FAIL negrem_timeout: no done"); end
    tests++; if (cnt[11] != 1) begin fails++; $display("FAIL negrem_c11: got %0d expected 1", cnt[11]); end
    tests++; if (cnt[12] != 1) begin fails++; $display("FAIL negrem_c12: got %0d expected 1", cnt[12]); end
    tests++; if (corr_split != 0) begin fails++; $display("FAIL negrem_split: got %0d expected 0", corr_split); end
    tests++; if (corr_seq_bad != 0) begin fails++; $display("FAIL negrem_then_c13: got %0d expected 0", corr_seq_bad); end
    tests++; if (cnt[13] != 1) begin fails++; $display("FAIL negrem_c13: got %0d expected 1", cnt[13]); end
  endtask

  task automatic test_div_zero();
    bit to;
    run_divide(8'h00, 9'h000, -1, to);
    tests++; if (to) begin fails++; $display("FAIL dbz_timeout: no done"); end
    tests++; if (bus.div_by_zero !== 1'b1) begin fails++; $display("FAIL dbz_flag: got %b expected 1", bus.div_by_zero); end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL dbz_done: got %0d expected 1", done_cnt); end
    tests++; if (cnt[2] + cnt[3] + cnt[8] + cnt[13] != 0) begin fails++;
      $display("FAIL dbz_strobes: c2=%0d c3=%0d c8=%0d c13=%0d expected all 0", cnt[2], cnt[3], cnt[8], cnt[13]); end
    run_divide(8'h90, 9'h000, -1, to);
    tests++; if (bus.div_by_zero !== 1'b0) begin fails++; $display("FAIL dbz_clear: got %b expected 0", bus.div_by_zero); end
    tests++; if (cnt[3] != 4) begin fails++; $display("FAIL dbz_next_c3: got %0d expected 4", cnt[3]); end
  endtask

  task automatic test_start_ignored();
    bit to;
    run_divide(8'h05, 9'h000, 6, to);
    tests++; if (to) begin fails++; $display("FAIL busy_start_timeout: no done"); end
    tests++; if (cnt[0] != 1) begin fails++; $display("FAIL busy_start_c0: got %0d expected 1", cnt[0]); end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL busy_start_done: got %0d expected 1", done_cnt); end
    tests++; if (cnt[2] != 5) begin fails++; $display("FAIL busy_start_c2: got %0d expected 5", cnt[2]); end
  endtask

  task automatic test_async_reset();
    bit found;
    bit to;
    b_init = 8'h90;
    bus.p_q = 9'h000;
    @(posedge clk); #1;
    clear_mon();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.c[3]) begin found = 1'b1; break; end
    end
    tests++; if (!found) begin fails++; $display("FAIL arst_reach_sh: c3 not seen within bound"); end
    #1 rst_b = 1'b0;
    #1;
    tests++; if (bus.c !== 15'h0) begin fails++; $display("FAIL arst_c: got %h expected 0", bus.c); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL arst_busy: got %b expected 0", bus.busy); end
    #1 rst_b = 1'b1;
    run_divide(8'h90, 9'h000, -1, to);
    tests++; if (to) begin fails++; $display("FAIL arst_rerun_timeout: no done"); end
    tests++; if (cnt[0] != 1 || cnt[1] != 1 || cnt[3] != 4 || cnt[13] != 1 || done_cnt != 1) begin fails++;
      $display("FAIL arst_rerun: c0=%0d c1=%0d c3=%0d c13=%0d done=%0d expected 1 1 4 1 1",
               cnt[0], cnt[1], cnt[3], cnt[13], done_cnt); end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.p_q   = 9'h000;
    b_init    = 8'h00;
    b_reg     = 8'h00;
    prev_c    = '0;
    clear_mon();
    test_reset();
    test_normalised();
    test_unnormalised(8'h05, 5);
    test_unnormalised(8'h01, 7);
    test_digit_decode();
    test_neg_remainder();
    test_div_zero();
    test_start_ignored();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
